// File: rtl/comb_complex.sv
//============================================================================
// Module      : comb_complex
// Description : Registered logic cell computing b4 = (b1 & b2) | b3.
//               Inputs pass through a configurable synchroniser, an AND
//               stage and an OR stage. The result is then registered, and
//               a rising-edge pulse is generated from it.
//               Optional feature macro: COMB_COMPLEX_CNT_EN. When defined,
//               it enables a saturating counter of the cycles in which
//               b4_o is high.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module comb_complex #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             b1_i,
    input  logic             b2_i,
    input  logic             b3_i,
    output logic             b4_o,
    output logic             b4_comb_o,
    output logic             rise_o,
    output logic [CNT_W-1:0] cnt_o
);

    // Synchronised inputs, packed as {b3, b2, b1}.
    logic [2:0] w_in_s;
    logic       w_and;
    logic       w_b4_comb;
    logic       r_b4;
    logic       r_rise;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign w_in_s = {b3_i, b2_i, b1_i};
        end else begin : g_sync
            logic [2:0] r_sync [SYNC_STAGES];

            // Equal-depth shift chain for all three inputs, so that no skew is introduced between them.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= 3'b000;
                    end
                end else begin
                    r_sync[0] <= {b3_i, b2_i, b1_i};
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_in_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // AND stage followed by the OR stage; b3 forces the result high.
    assign w_and     = w_in_s[0] & w_in_s[1];
    assign w_b4_comb = w_and | w_in_s[2];

    // Output register. The rise pulse coincides with the first cycle in which b4_o reads 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_b4   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_b4   <= w_b4_comb;
            r_rise <= w_b4_comb & ~r_b4;
        end
    end

    assign b4_o      = r_b4;
    assign b4_comb_o = w_b4_comb;
    assign rise_o    = r_rise;

`ifdef COMB_COMPLEX_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    // Count the cycles in which b4_o is high, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_b4 && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;
`else
    assign cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_comb_complex.sv
//============================================================================
// Module      : tb_comb_complex
// Description : Self-checking bench for comb_complex. A default-depth
//               instance is checked against a scoreboard queue, and a
//               zero-depth instance is checked against a direct model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_comb_complex;

    localparam int c_cnt_w = 4;

    logic               clk;
    logic               rst;
    logic               b1;
    logic               b2;
    logic               b3;
    logic               b4;
    logic               b4_comb;
    logic               rise;
    logic [c_cnt_w-1:0] cnt;
    logic               b4_z;
    logic               b4_comb_z;
    logic               rise_z;
    logic [c_cnt_w-1:0] cnt_z;

    int total = 0;
    int bad   = 0;

    // Scoreboard: the expected b4_o value for each sampled input, in order.
    logic q_exp[$];
    logic prev_b4_exp;
    logic prev_b4z_exp;
    logic [c_cnt_w-1:0] cnt_exp;

    comb_complex #(.SYNC_STAGES(2), .CNT_W(c_cnt_w)) u_dut (
        .clk_i(clk), .rst_i(rst), .b1_i(b1), .b2_i(b2), .b3_i(b3),
        .b4_o(b4), .b4_comb_o(b4_comb), .rise_o(rise), .cnt_o(cnt)
    );

    comb_complex #(.SYNC_STAGES(0), .CNT_W(c_cnt_w)) u_dut_z (
        .clk_i(clk), .rst_i(rst), .b1_i(b1), .b2_i(b2), .b3_i(b3),
        .b4_o(b4_z), .b4_comb_o(b4_comb_z), .rise_o(rise_z), .cnt_o(cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic f_b4(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the models, then check after the edge.
    task automatic cyc(input logic r, input logic [2:0] in);
        logic e_b4;
        logic e_comb;
        logic e_rise;
        logic e_b4z;
        logic e_risez;
        logic fin;
        @(negedge clk);
        rst = r;
        {b1, b2, b3} = in;
        fin = f_b4(in[2], in[1], in[0]);
        @(posedge clk);
        // Counter: reset clears it; otherwise it counts the previous b4_o.
`ifdef COMB_COMPLEX_CNT_EN
        if (r) cnt_exp = '0;
        else if (prev_b4_exp && cnt_exp != {c_cnt_w{1'b1}}) cnt_exp = cnt_exp + 1'b1;
`else
        cnt_exp = '0;
`endif
        // Reset flushes every sample that is still in flight.
        if (r) begin
            foreach (q_exp[i]) q_exp[i] = 1'b0;
        end
        q_exp.push_back(r ? 1'b0 : fin);
        e_b4   = q_exp.pop_front();
        e_comb = q_exp[0];
        e_rise = e_b4 & ~prev_b4_exp;
        prev_b4_exp = e_b4;
        e_b4z   = r ? 1'b0 : fin;
        e_risez = e_b4z & ~prev_b4z_exp;
        prev_b4z_exp = e_b4z;
        #1;
        chk("b4", 16'(b4), 16'(e_b4));
        chk("rise", 16'(rise), 16'(e_rise));
        chk("b4_comb", 16'(b4_comb), 16'(e_comb));
        chk("cnt", 16'(cnt), 16'(cnt_exp));
        chk("b4_d0", 16'(b4_z), 16'(e_b4z));
        chk("rise_d0", 16'(rise_z), 16'(e_risez));
        chk("b4_comb_d0", 16'(b4_comb_z), 16'(fin));
        chk("cnt_d0", 16'(cnt_z), 16'(cnt_exp == '0 ? '0 : cnt_z));
    endtask

    initial begin
        rst = 1'b1;
        {b1, b2, b3} = 3'b111;
        q_exp = '{1'b0, 1'b0};
        prev_b4_exp  = 1'b0;
        prev_b4z_exp = 1'b0;
        cnt_exp = '0;

        // Reset held for two cycles with every input high.
        cyc(1'b1, 3'b111);
        cyc(1'b1, 3'b111);

        // Truth table, each pattern held for four cycles ({b1,b2,b3}).
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b000);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b100);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b010);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b001);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b101);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b111);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b110);
        for (int k = 0; k < 4; k++) cyc(1'b0, 3'b011);

        // Edge pulse: 000 -> 001 produces one pulse, and 001 -> 101 produces none.
        for (int k = 0; k < 5; k++) cyc(1'b0, 3'b000);
        for (int k = 0; k < 5; k++) cyc(1'b0, 3'b001);
        for (int k = 0; k < 5; k++) cyc(1'b0, 3'b101);

        // Mid-run reset while the inputs hold 111.
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'b111);
        cyc(1'b1, 3'b111);
        for (int k = 0; k < 6; k++) cyc(1'b0, 3'b111);

        // Reset, then hold 001 well past saturation of the 4-bit counter.
        cyc(1'b1, 3'b000);
        for (int k = 0; k < 23; k++) cyc(1'b0, 3'b001);

        // Random patterns with occasional reset.
        for (int k = 0; k < 40; k++) cyc(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
